// File: rtl/ahb_burst_tracker_pkg.sv
// Shared types for the AHB burst tracker: transfer/burst encodings,
// tracker FSM states and the burst-length decode.
package ahb_burst_tracker_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'd0,
      TR_BUSY   = 2'd1,
      TR_NONSEQ = 2'd2,
      TR_SEQ    = 2'd3
   } trans_e;

   typedef enum logic [2:0] {
      BR_SINGLE = 3'd0,
      BR_INCR   = 3'd1,
      BR_WRAP4  = 3'd2,
      BR_INCR4  = 3'd3,
      BR_WRAP8  = 3'd4,
      BR_INCR8  = 3'd5,
      BR_WRAP16 = 3'd6,
      BR_INCR16 = 3'd7
   } burst_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_e;

   // Zero means undefined length (INCR)
   function automatic logic [4:0] burst_len(input logic [2:0] b);
      case (b)
         3'd0:       return 5'd1;
         3'd1:       return 5'd0;
         3'd2, 3'd3: return 5'd4;
         3'd4, 3'd5: return 5'd8;
         default:    return 5'd16;
      endcase
   endfunction

   function automatic logic is_wrap(input logic [2:0] b);
      return (b[0] == 1'b0) && (b != 3'd0);
   endfunction

endpackage

// File: rtl/ahb_burst_tracker_if.sv
// AHB-Lite input side plus the per-beat request bundle to the
// I-cache lookup stage.
interface ahb_burst_tracker_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int OFF_W      = 2
);
   logic [ADDR_WIDTH-1:0] haddr;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [1:0]            htrans;
   logic                  hready;
   logic [DATA_WIDTH-1:0] hwdata;

   logic [ADDR_WIDTH-1:0] read_addr;
   logic [OFF_W-1:0]      read_addr_offset;
   logic [1:0]            trans_out;
   logic                  beat_valid;
   logic                  beat_write;
   logic [3:0]            beat_idx;
   logic                  burst_last;
   logic [DATA_WIDTH-1:0] wdata_out;
   logic                  wdata_valid;
   logic                  burst_err;

   modport master (
      output haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
      input  read_addr, read_addr_offset, trans_out, beat_valid,
             beat_write, beat_idx, burst_last, wdata_out,
             wdata_valid, burst_err
   );

   modport slave (
      input  haddr, hwrite, hsize, hburst, htrans, hready, hwdata,
      output read_addr, read_addr_offset, trans_out, beat_valid,
             beat_write, beat_idx, burst_last, wdata_out,
             wdata_valid, burst_err
   );
endinterface

// File: rtl/ahb_burst_tracker_addr_predictor.sv
// Combinational next-beat address and burst length from the
// current AHB address phase.
module ahb_burst_tracker_addr_predictor
   import ahb_burst_tracker_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] haddr_i,
   input  logic [2:0]            hsize_i,
   input  logic [2:0]            hburst_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o,
   output logic [4:0]            len_o
);
   logic [ADDR_WIDTH-1:0] sz;
   logic [ADDR_WIDTH-1:0] mask;
   logic [ADDR_WIDTH-1:0] incr;

   always_comb begin
      len_o = burst_len(hburst_i);
      sz    = ADDR_WIDTH'(1) << hsize_i;
      mask  = (ADDR_WIDTH'(len_o) << hsize_i) - ADDR_WIDTH'(1);
      incr  = haddr_i + sz;
      next_addr_o = is_wrap(hburst_i)
                  ? ((haddr_i & ~mask) | (incr & mask))
                  : incr;
   end
endmodule

// File: rtl/ahb_burst_tracker.sv
// AHB-Lite burst capture front end feeding the I-cache lookup stage.
// Build option BURST_ADDR_CHECK_EN adds predicted-address checks on SEQ beats.
module ahb_burst_tracker
   import ahb_burst_tracker_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_BYTES = 16
) (
   input logic                clk,
   input logic                rst,
   ahb_burst_tracker_if.slave bus
);
   localparam int LO = $clog2(DATA_WIDTH / 8);
   localparam int HI = $clog2(LINE_BYTES) - 1;
   localparam int OFF_W = HI - LO + 1;
   localparam logic [2:0] MAX_SZ = 3'(LO);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic [1:0]            trans_q, trans_d;
   logic                  bvalid_q, bvalid_d;
   logic                  write_q, write_d;
   logic                  last_q, last_d;
   logic [3:0]            idx_q, idx_d;
   logic [4:0]            len_q, len_d, len_in;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wvalid_q, wvalid_d;
   logic                  wpend_q, wpend_d;
   logic                  err_q, err_d;
   logic                  accept, nonseq_acc, seq_acc, idle_end;
   logic                  err_set, size_err, final_beat, addr_err;
   logic [ADDR_WIDTH-1:0] sz_mask;

`ifdef BURST_ADDR_CHECK_EN
   logic [ADDR_WIDTH-1:0] pred_q, next_addr;
   logic [2:0]            burst_q;

   ahb_burst_tracker_addr_predictor #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pred (
      .haddr_i     (bus.haddr),
      .hsize_i     (bus.hsize),
      .hburst_i    (bus.hburst),
      .next_addr_o (next_addr),
      .len_o       (len_in)
   );

   assign addr_err = (bus.haddr != pred_q) | (bus.hburst != burst_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         pred_q  <= '0;
         burst_q <= '0;
      end else begin
         if (accept)     pred_q  <= next_addr;
         if (nonseq_acc) burst_q <= bus.hburst;
      end
   end
`else
   assign len_in   = burst_len(bus.hburst);
   assign addr_err = 1'b0;
`endif

   assign accept     = bus.hready & bus.htrans[1];
   assign nonseq_acc = accept & ~bus.htrans[0];
   assign seq_acc    = accept & bus.htrans[0];
   assign idle_end   = (state_q == S_BURST) & bus.hready
                     & (bus.htrans == TR_IDLE);
   assign sz_mask    = (ADDR_WIDTH'(1) << bus.hsize) - ADDR_WIDTH'(1);
   assign size_err   = (bus.hsize > MAX_SZ) | (|(bus.haddr & sz_mask));
   assign final_beat = (len_q != 5'd0) & (({1'b0, idx_q} + 5'd2) == len_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      len_d    = len_q;
      err_set  = accept & size_err;
      bvalid_d = accept;
      addr_d   = accept ? bus.haddr : addr_q;
      off_d    = accept ? bus.haddr[HI:LO] : off_q;
      write_d  = accept ? bus.hwrite : write_q;
      trans_d  = bus.hready ? bus.htrans : trans_q;
      unique case (1'b1)
         nonseq_acc: begin
            idx_d   = 4'd0;
            last_d  = (bus.hburst == BR_SINGLE);
            len_d   = len_in;
            state_d = (bus.hburst == BR_SINGLE) ? S_IDLE : S_BURST;
            if ((state_q == S_BURST) && (len_q != 5'd0)) err_set = 1'b1;
         end
         seq_acc & (state_q == S_IDLE): begin
            idx_d   = 4'd0;
            last_d  = 1'b0;
            err_set = 1'b1;
         end
         seq_acc & (state_q == S_BURST): begin
            idx_d  = (idx_q == 4'hF) ? idx_q : idx_q + 4'd1;
            last_d = final_beat;
            if (final_beat) state_d = S_IDLE;
            if (addr_err)   err_set = 1'b1;
         end
         idle_end: begin
            state_d = S_IDLE;
            if (len_q != 5'd0) err_set = 1'b1;
         end
         default: ;
      endcase
      err_d = (err_q & ~nonseq_acc) | err_set;
      // Write data lands in the first ready cycle after its address phase
      wpend_d  = accept ? bus.hwrite : (bus.hready ? 1'b0 : wpend_q);
      wvalid_d = wpend_q & bus.hready;
      wdata_d  = (wpend_q & bus.hready) ? bus.hwdata : wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         off_q    <= '0;
         trans_q  <= TR_IDLE;
         bvalid_q <= 1'b0;
         write_q  <= 1'b0;
         last_q   <= 1'b0;
         idx_q    <= '0;
         len_q    <= '0;
         wdata_q  <= '0;
         wvalid_q <= 1'b0;
         wpend_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         off_q    <= off_d;
         trans_q  <= trans_d;
         bvalid_q <= bvalid_d;
         write_q  <= write_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         wdata_q  <= wdata_d;
         wvalid_q <= wvalid_d;
         wpend_q  <= wpend_d;
         err_q    <= err_d;
      end
   end

   assign bus.read_addr        = addr_q;
   assign bus.read_addr_offset = off_q;
   assign bus.trans_out        = trans_q;
   assign bus.beat_valid       = bvalid_q;
   assign bus.beat_write       = write_q;
   assign bus.beat_idx         = idx_q;
   assign bus.burst_last       = last_q;
   assign bus.wdata_out        = wdata_q;
   assign bus.wdata_valid      = wvalid_q;
   assign bus.burst_err        = err_q;
endmodule

// File: doc/ahb_burst_tracker.md
Name: ahb_burst_tracker

Overview:
Parametrised successor to the cache's AHB transfer front end. Captures AHB address and data phases for every AHB-Lite burst type (SINGLE, INCR, WRAP4/8/16, INCR4/8/16) and tracks beat count and predicted next address. Emits a registered per-beat request (address, line word offset, beat index, last flag) to the I-cache lookup stage. Flags protocol violations.

Parameters:
ADDR_WIDTH, 32, haddr/read_addr width
DATA_WIDTH, 32, hwdata width; 32, 64 or 128
LINE_BYTES, 16, cache line size in bytes (power of two, >= DATA_WIDTH/8); sets read_addr_offset width

Ports:
clk  in  1  system clock
rst  in  1  one clock; reset is synchronous and active-high
haddr  in  ADDR_WIDTH  AHB address
hwrite  in  1  AHB write flag
hsize  in  3  AHB transfer size
hburst  in  3  AHB burst type
htrans  in  2  AHB transfer type
hready  in  1  AHB ready
hwdata  in  DATA_WIDTH  AHB write data
read_addr  out  ADDR_WIDTH  captured beat address
read_addr_offset  out  OFF_W=log2(LINE_BYTES*8/DATA_WIDTH)  word index within line
trans_out  out  2  captured htrans of beat
beat_valid  out  1  one-cycle pulse per accepted beat
beat_write  out  1  captured hwrite
beat_idx  out  4  beat number within burst, 0-based
burst_last  out  1  beat is final beat of fixed-length burst or SINGLE
wdata_out  out  DATA_WIDTH  captured write data
wdata_valid  out  1  one-cycle pulse when wdata_out updated
burst_err  out  1  sticky protocol error; cleared on next accepted NONSEQ

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0; trans_out=IDLE (2'b00); FSM=S_IDLE; beat counter, predicted address 0. Reset mid-burst aborts the burst with no further pulses.
- Encodings: htrans IDLE=0, BUSY=1, NONSEQ=2, SEQ=3. hburst SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7. Beat length 1/undef/4/4/8/8/16/16.
- accept = hready & htrans[1]. On accept, next cycle: beat_valid=1, and read_addr, trans_out, beat_write, beat_idx, burst_last load. read_addr_offset = haddr[log2(LINE_BYTES)-1 : log2(DATA_WIDTH/8)]. Latency 1 clk.
- No accept (hready=0, IDLE, BUSY): beat_valid=0. Data outputs hold. trans_out is IDLE or BUSY when hready=1, else holds. BUSY never advances the beat count.
- Data phase: the cycle after a write accept, wdata is pending. At the first following edge with hready=1, wdata_out<=hwdata and wdata_valid=1. A new accept in that same cycle is handled independently (pipelined).
- FSM S_IDLE/S_BURST:
  - S_IDLE + NONSEQ accept: beat_idx=0. Go to S_BURST unless SINGLE; SINGLE sets burst_last=1.
  - S_IDLE + SEQ accept: burst_err=1, beat emitted, stay S_IDLE.
  - S_BURST + SEQ accept: beat_idx+1. On final beat of a fixed burst, burst_last=1 and go to S_IDLE.
  - S_BURST + hready&IDLE: go to S_IDLE; burst_err=1 unless INCR.
  - S_BURST + NONSEQ: start a new burst; burst_err=1 unless INCR.
- Prediction on each accept, with sz=1<<hsize:
  - INCR types: next=haddr+sz (mod 2^ADDR_WIDTH).
  - WRAP types: B=len*sz; next=(haddr & ~(B-1)) | ((haddr+sz)&(B-1)).
- hsize > log2(DATA_WIDTH/8), or haddr misaligned to sz, on accept: burst_err=1; beat still emitted.
- INCR: beat_idx saturates at 15; burst_last stays 0.

Optional Feature:
BURST_ADDR_CHECK_EN. Defined: each SEQ accept in S_BURST compares haddr to the predicted address, or hburst to the latched hburst; any mismatch sets burst_err. Undefined: comparator and predicted-address register are removed; SEQ accepted without an address check. All other behaviour is identical.

Decomposition:
interface_pkg: TRANS_TYPES and BURST_TYPES enums, burst-length function, FSM state enum. One sub-module, ahb_addr_predictor: combinational next-address and beat-length from haddr/hsize/hburst. Instantiated only under BURST_ADDR_CHECK_EN; otherwise only the length function is used.

Test Plan:
- SINGLE read NONSEQ haddr=0x1000_0008, hready=1 -> next cycle beat_valid=1, read_addr=0x1000_0008, offset=2, burst_last=1, burst_err=0.
- WRAP4 word read from 0x38: SEQ 0x3C,0x30,0x34 -> beat_idx 0..3, offsets 2,3,0,1, burst_last only on 4th, FSM back to S_IDLE.
- INCR8 with hready low 2 cycles mid-burst and one BUSY -> exactly 8 beat_valid pulses, outputs held during stalls.
- Write INCR4 at 0x200, hwdata 0xA5A5_0000+i -> wdata_valid 4 pulses, values in order, each one edge after the matching data phase.
- INCR4 cut by IDLE after 2 beats -> burst_err=1, cleared by next NONSEQ; with BURST_ADDR_CHECK_EN, SEQ at 0x208 where 0x204 is predicted -> burst_err=1.
- rst asserted during beat 3 of INCR16 -> next cycle all outputs 0, trans_out=IDLE; following NONSEQ gives beat_idx=0.
